mdio_master: RTL and testbench
==============================

# mdio_master

Parametrised Clause-22 MDIO management master for the Ethernet PHY, and the successor to the fixed-address, fixed-rate MDIO block. It generates a divided MDC, takes the PHY address at run time, and can suppress the preamble. It verifies the PHY's turnaround acknowledge on reads and exposes split tri-state pins (`mdio_o`/`mdio_oe`/`mdio_i`) for a top-level IO buffer. It sits between the Ethernet init/management sequencer and the PHY pins.

## Interface
- `CLK_DIV`, default 10: system clocks per MDC half-period; legal range 1..255.
- `PREAMBLE_LEN`, default 32: number of preamble ones; legal range 1..63.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `phy_addr`  in  5  PHY address; sampled when a request is accepted.
- `reg_addr`  in  5  register address; sampled when a request is accepted.
- `wr_data`  in  16  write data; sampled when a request is accepted.
- `no_preamble`  in  1  1 = omit the preamble for this frame; sampled when a request is accepted.
- `rd_request`  in  1  start a read; accepted only while `ready`=1.
- `wr_request`  in  1  start a write; accepted only while `ready`=1.
- `ready`  out  1  1 = idle and able to accept a request.
- `rd_data`  out  16  last read data; holds its value until the next read completes.
- `rd_valid`  out  1  one-cycle pulse when a read completes.
- `rd_error`  out  1  1 = the last read got no turnaround acknowledge; updated with `rd_valid`.
- `mdc`  out  1  management clock.
- `mdio_o`  out  1  serial data out.
- `mdio_oe`  out  1  output enable for `mdio_o`.
- `mdio_i`  in  1  serial data in, from the pad.

## Operation
- Reset values (any clock edge with `reset_n`=0, including mid-frame): state IDLE, `ready`=1, `mdc`=0, `mdio_oe`=0, `mdio_o`=1, `rd_data`=0, `rd_valid`=0, `rd_error`=0. The divider and bit counters clear. An aborted frame is not resumed.
- States: IDLE -> PRE -> HDR -> TA -> DATA -> DONE -> IDLE.
  - If `no_preamble`=1, IDLE goes straight to HDR.
- Request acceptance:
  - If both requests are high in the same cycle, the read wins and the write is dropped.
  - Requests made while `ready`=0 are ignored; they are not queued.
- Frame, MSB first:
  - PRE: `PREAMBLE_LEN` ones.
  - HDR, 14 bits: ST=01, OP=01 for a write or 10 for a read, then `phy_addr`[4:0], then `reg_addr`[4:0].
  - TA: 10 for a write. For a read, `mdio_oe`=0 for both TA bits.
  - DATA: 16 bits. For a write, `wr_data` is driven. For a read, `mdio_oe`=0 and bits are shifted into the read shift register.
- MDC generation:
  - A divider counts 0..`CLK_DIV`-1. At the terminal count, `mdc` toggles.
  - `mdc` toggles only outside IDLE; it stays 0 in IDLE.
- Bit timing:
  - `mdio_o`/`mdio_oe` change only in the cycle where `mdc` goes 1->0, and at frame start.
  - `mdio_i` is sampled in the cycle where `mdc` goes 0->1.
- Read acknowledge:
  - The second TA bit is sampled. If it is 1 (no PHY driving), `rd_error` is set.
  - The data bits are still shifted, so `rd_data`=16'hFFFF for a floating bus.
- DONE (one cycle): `mdio_oe`=0, `mdio_o`=1. For a read, `rd_data` and `rd_error` are loaded and `rd_valid`=1.
- Bit counting: the bit counter is 6 bits wide and holds the remaining bits of the current field. No wrap past 0; the field change happens at 0.

## Timing
- Request accepted in cycle T. In T+1: `ready`=0, `mdio_oe`=1, first bit on `mdio_o`, `mdc`=0.
- MDC period: 2*`CLK_DIV` clocks, 50% duty. The first rising edge is at T+1+`CLK_DIV`.
- Frame length N MDC periods: N = `PREAMBLE_LEN`+32, or 32 when `no_preamble`=1.
- Completion: DONE in cycle T+1+2*`CLK_DIV`*N. `ready`=1 and the `rd_valid` pulse occur in that same cycle. A new request is accepted in that cycle.
- Read release: `mdio_oe` falls at the start of TA. This is the falling-MDC cycle that ends REGAD bit 0.
- Output enable on writes: `mdio_oe` stays 1 from T+1 through the last data bit.

## Test plan
- Write, `CLK_DIV`=2, `PREAMBLE_LEN`=32: `phy_addr`=5'h07, `reg_addr`=5'h00, `wr_data`=16'h1140 -> the bit stream captured on `mdc` rising is 32 ones, then 01 01 00111 00000 10 0001000101000000. Exactly 64 `mdc` rising edges; `ready` returns at T+257; `rd_valid` stays 0.
- Read with a PHY model at address 7 returning 16'hABCD -> `mdio_oe`=0 from TA onward; the model drives TA bit 2 as 0. Result: `rd_data`=16'hABCD, `rd_error`=0, a single `rd_valid` pulse coincident with `ready` rising.
- Read with `mdio_i` pulled high (no PHY) -> `rd_error`=1, `rd_data`=16'hFFFF, `rd_valid` pulses.
- `no_preamble`=1 read, `CLK_DIV`=1 -> frame starts with 01 10; 32 `mdc` rising edges; `ready` returns at T+65.
- `rd_request` and `wr_request` both high -> OP=10 is sent and the write is dropped. A further request held during the busy period is ignored; no second frame starts.
- `reset_n` low for 1 cycle during DATA of a write -> on the next edge: `ready`=1, `mdc`=0, `mdio_oe`=0, `rd_data`=0. A subsequent read completes normally.

Source files
------------

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO master with divided MDC, run-time PHY address,
// optional preamble and turnaround-acknowledge check on reads.
module mdio_master #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  input  logic        no_preamble,
  input  logic        rd_request,
  input  logic        wr_request,
  output logic        ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_error,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;
  state_t      state;
  logic [7:0]  div;
  logic [5:0]  cnt;
  logic [31:0] tx, frame;
  logic [15:0] rx;
  logic        is_rd, ack_err, tick, start;
  assign tick  = div == 8'(CLK_DIV - 1);
  assign start = ready && (rd_request || wr_request);
  // ST, OP, PHYAD, REGAD, TA, DATA; read wins when both requests are high
  assign frame = {2'b01, rd_request ? 2'b10 : 2'b01, phy_addr, reg_addr, 2'b10, wr_data};
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      mdc      <= 1'b0;
      mdio_oe  <= 1'b0;
      mdio_o   <= 1'b1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_error <= 1'b0;
      div      <= '0;
      cnt      <= '0;
      tx       <= '0;
      rx       <= '0;
      is_rd    <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (start) begin
        state   <= no_preamble ? HDR : PRE;
        cnt     <= no_preamble ? 6'd13 : 6'(PREAMBLE_LEN - 1);
        is_rd   <= rd_request;
        ready   <= 1'b0;
        mdc     <= 1'b0;
        div     <= '0;
        mdio_oe <= 1'b1;
        mdio_o  <= no_preamble ? frame[31] : 1'b1;
        tx      <= no_preamble ? {frame[30:0], 1'b1} : frame;
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (state != IDLE) begin
        div <= tick ? '0 : div + 8'd1;
        if (tick) mdc <= ~mdc;
        // rising MDC: sample the acknowledge bit and shift in data
        if (tick && !mdc && state == TA && cnt == 6'd0) ack_err <= mdio_i;
        if (tick && !mdc && state == DATA) rx <= {rx[14:0], mdio_i};
        if (tick && mdc) begin
          if (state == DATA && cnt == 6'd0) begin
            state   <= DONE;
            ready   <= 1'b1;
            mdio_oe <= 1'b0;
            mdio_o  <= 1'b1;
            div     <= '0;
            if (is_rd) begin
              rd_data  <= rx;
              rd_error <= ack_err;
              rd_valid <= 1'b1;
            end
          end else if (state == PRE && cnt != 6'd0) begin
            cnt    <= cnt - 6'd1;
            mdio_o <= 1'b1;
          end else begin
            {mdio_o, tx} <= {tx, 1'b1};
            if (cnt != 6'd0) cnt <= cnt - 6'd1;
            else begin
              state <= state == PRE ? HDR : state == HDR ? TA : DATA;
              cnt   <= state == PRE ? 6'd13 : state == HDR ? 6'd1 : 6'd15;
              if (state == HDR) mdio_oe <= !is_rd;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: table-driven MDIO frames checked through a scoreboard and PHY model,
// plus hand-written reset-abort, arbitration and no-preamble/CLK_DIV=1 sequences.
module tb_mdio_master;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [4:0] phy_addr = '0, reg_addr = '0;
  logic [15:0] wr_data = '0;
  logic no_preamble = 1'b0, rd_request = 1'b0, wr_request = 1'b0, rd_req_b = 1'b0;
  logic ready, rd_valid, rd_error, mdc, mdio_o, mdio_oe, line;
  logic [15:0] rd_data;
  logic ready_b, rd_valid_b, rd_error_b, mdc_b, mdio_o_b, mdio_oe_b, line_b;
  logic [15:0] rd_data_b;
  logic phy_drv, phy_bit, phy_en = 1'b0;
  logic [15:0] phy_word = '0;
  localparam logic [4:0] PHY_AT = 5'h07;
  typedef struct {
    logic rd, wr, np;
    logic [4:0] phy, rg;
    logic [15:0] wd;
    logic phy_en;
    logic [15:0] phy_word, exp_rdata;
    logic exp_err;
  } vec_t;
  typedef struct {
    logic is_rd;
    int nbits;
    logic [63:0] stream;
    logic [15:0] rdata;
    logic rerr;
  } exp_t;
  exp_t sb[$];
  vec_t vt[8];
  int n_cmp = 0, n_err = 0, n_start = 0, n_issued = 0, cyc = 0;
  int rise = 0, st_idx = -1, oe_cnt = 0, vcnt = 0, t0 = 0, rel;
  logic in_frm = 1'b0, mdc_q = 1'b0, ready_q = 1'b1;
  logic [63:0] cap = '0, last_cap = '0;
  logic [1:0] op_seen = '0;
  logic [4:0] adr_seen = '0;
  logic [15:0] last_rd = '0;
  logic last_err = 1'b0;

  always #5 clock = ~clock;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .phy_addr(phy_addr), .reg_addr(reg_addr),
    .wr_data(wr_data), .no_preamble(no_preamble), .rd_request(rd_request),
    .wr_request(wr_request), .ready(ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_error(rd_error), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(line)
  );
  mdio_master #(.CLK_DIV(1), .PREAMBLE_LEN(32)) dut_b (
    .clock(clock), .reset_n(reset_n), .phy_addr(phy_addr), .reg_addr(reg_addr),
    .wr_data(wr_data), .no_preamble(no_preamble), .rd_request(rd_req_b),
    .wr_request(1'b0), .ready(ready_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .rd_error(rd_error_b), .mdc(mdc_b), .mdio_o(mdio_o_b), .mdio_oe(mdio_oe_b), .mdio_i(line_b)
  );

  // Pad model: master drives when enabled, else the PHY, else the pull-up
  assign rel    = rise - st_idx;
  assign line   = mdio_oe ? mdio_o : phy_drv ? phy_bit : 1'b1;
  assign line_b = mdio_oe_b ? mdio_o_b : 1'b1;

  // PHY at PHY_AT answers reads: TA bit 2 low, then 16 data bits MSB first
  always_comb begin
    phy_drv = 1'b0;
    phy_bit = 1'b1;
    if (phy_en && in_frm && st_idx >= 0 && op_seen == 2'b10 && adr_seen == PHY_AT && rel >= 15 && rel <= 31) begin
      phy_drv = 1'b1;
      phy_bit = rel == 15 ? 1'b0 : phy_word[4'(31 - rel)];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame monitor: captures the line on every MDC rise and scores each completed frame
  always @(negedge clock) begin
    exp_t e;
    logic [63:0] m;
    cyc++;
    if (!reset_n) begin
      if (in_frm && sb.size() > 0) sb.delete(0);
      in_frm = 1'b0;
    end else begin
      if (in_frm && mdc && !mdc_q) begin
        cap = {cap[62:0], line};
        if (mdio_oe) oe_cnt++;
        if (st_idx < 0 && !line) st_idx = rise;
        if (st_idx >= 0 && rise - st_idx == 3) op_seen = cap[1:0];
        if (st_idx >= 0 && rise - st_idx == 8) adr_seen = cap[4:0];
        rise++;
      end
      if (in_frm && rd_valid) vcnt++;
      if (in_frm && ready && !ready_q) begin
        in_frm = 1'b0;
        last_cap = cap;
        if (sb.size() == 0) chk("unexpected_frame", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          m = e.nbits == 64 ? '1 : 64'hFFFF_FFFF;
          chk("mdc_rises", 64'(rise), 64'(e.nbits));
          chk("frame_cycles", 64'(cyc - t0), 64'(4 * e.nbits));
          chk("bit_stream", cap & m, e.stream & m);
          chk("oe_rises", 64'(oe_cnt), 64'(e.is_rd ? e.nbits - 18 : e.nbits));
          chk("rd_valid_pulses", 64'(vcnt), 64'(e.is_rd));
          chk("rd_data", 64'(rd_data), 64'(e.rdata));
          chk("rd_error", 64'(rd_error), 64'(e.rerr));
        end
      end
      if (!in_frm && ready_q && !ready) begin
        in_frm = 1'b1;
        n_start++;
        t0 = cyc;
        rise = 0;
        st_idx = -1;
        oe_cnt = 0;
        vcnt = 0;
        cap = '0;
        op_seen = '0;
        adr_seen = '0;
        chk("start_oe", 64'(mdio_oe), 64'd1);
        chk("start_mdc", 64'(mdc), 64'd0);
      end
    end
    mdc_q = mdc;
    ready_q = ready;
  end

  task automatic issue(input vec_t v);
    exp_t e;
    logic resp;
    int k;
    k = 0;
    @(negedge clock);
    while (!ready && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (!ready) chk("ready_timeout", 64'd0, 64'd1);
    phy_addr = v.phy;
    reg_addr = v.rg;
    wr_data = v.wd;
    no_preamble = v.np;
    phy_en = v.phy_en;
    phy_word = v.phy_word;
    rd_request = v.rd;
    wr_request = v.wr;
    resp = v.rd && v.phy_en && v.phy == PHY_AT;
    e.is_rd = v.rd;
    e.nbits = v.np ? 32 : 64;
    e.stream = {32'hFFFF_FFFF, 2'b01, v.rd ? 2'b10 : 2'b01, v.phy, v.rg,
                v.rd ? {1'b1, !resp} : 2'b10, v.rd ? (resp ? v.phy_word : 16'hFFFF) : v.wd};
    if (v.rd) begin
      last_rd = v.exp_rdata;
      last_err = v.exp_err;
    end
    e.rdata = last_rd;
    e.rerr = last_err;
    sb.push_back(e);
    n_issued++;
    @(posedge clock);
    #1;
    rd_request = 1'b0;
    if (v.rd && v.wr) begin
      repeat (60) @(posedge clock);
      #1;
    end
    wr_request = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clock);
      #1;
      k++;
    end while ((in_frm || !ready) && k < 5000);
    if (in_frm || !ready) chk("frame_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int k, n, nr;
    logic mq;
    logic [3:0] first;
    vt[0] = '{1'b0, 1'b1, 1'b0, 5'h07, 5'h00, 16'h1140, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 5'h07, 5'h01, 16'h0000, 1'b1, 16'hABCD, 16'hABCD, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 5'h07, 5'h02, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b1, 5'h1F, 5'h1F, 16'hA5A5, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b1, 5'h07, 5'h1F, 16'h0000, 1'b1, 16'h1234, 16'h1234, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 5'h07, 5'h03, 16'hFFFF, 1'b1, 16'h0F0F, 16'h0F0F, 1'b0};
    vt[6] = '{1'b0, 1'b1, 1'b0, 5'h00, 5'h00, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 5'h03, 5'h05, 16'h0000, 1'b1, 16'h5A5A, 16'hFFFF, 1'b1};
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_mdc", 64'(mdc), 64'd0);
    chk("rst_oe", 64'(mdio_oe), 64'd0);
    chk("rst_mdio_o", 64'(mdio_o), 64'd1);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_error", 64'(rd_error), 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(vt[i]);
      wait_idle();
      if (i == 0) chk("spec_write_stream", last_cap, {32'hFFFF_FFFF, 32'h5382_1140});
    end
    // Reset for one cycle in the middle of a write's data phase
    issue('{1'b0, 1'b1, 1'b0, 5'h07, 5'h04, 16'hBEEF, 1'b1, 16'h0000, 16'h0000, 1'b0});
    k = 0;
    do begin
      @(negedge clock);
      #1;
      k++;
    end while (!(in_frm && rise >= 56) && k < 2000);
    if (!(in_frm && rise >= 56)) chk("data_phase_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_mdc", 64'(mdc), 64'd0);
    chk("abort_oe", 64'(mdio_oe), 64'd0);
    chk("abort_mdio_o", 64'(mdio_o), 64'd1);
    chk("abort_rd_data", 64'(rd_data), 64'd0);
    chk("abort_rd_error", 64'(rd_error), 64'd0);
    last_rd = '0;
    last_err = 1'b0;
    issue(vt[1]);
    wait_idle();
    // No-preamble read at CLK_DIV=1 on a floating bus
    @(negedge clock);
    phy_addr = 5'h07;
    reg_addr = 5'h02;
    no_preamble = 1'b1;
    rd_req_b = 1'b1;
    @(posedge clock);
    #1 rd_req_b = 1'b0;
    @(negedge clock);
    chk("b_start_ready", 64'(ready_b), 64'd0);
    n = 0;
    nr = 0;
    mq = 1'b0;
    first = '0;
    while (!ready_b && n < 500) begin
      @(negedge clock);
      n++;
      if (mdc_b && !mq) begin
        if (nr < 4) first = {first[2:0], line_b};
        nr++;
      end
      mq = mdc_b;
    end
    chk("b_frame_cycles", 64'(n), 64'd64);
    chk("b_mdc_rises", 64'(nr), 64'd32);
    chk("b_st_op", 64'(first), 64'b0110);
    chk("b_rd_valid", 64'(rd_valid_b), 64'd1);
    chk("b_rd_error", 64'(rd_error_b), 64'd1);
    chk("b_rd_data", 64'(rd_data_b), 64'hFFFF);
    repeat (20) @(negedge clock);
    chk("frames_started", 64'(n_start), 64'(n_issued));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
